// File: rtl/seven_seg_scanner.sv
// Eight-digit multiplexed hex display driver for a common-anode module.
// A frame shadow keeps all eight digits of one frame from the same data word.
module seven_seg_scanner #(
  parameter int DIGIT_CYCLES = 100_000,
  parameter int BLANK_CYCLES = 1_000,
  parameter bit LZ_BLANK     = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic        en_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLNK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   shadow;
  logic [3:0]    nib;
  logic [6:0]    dec;
  logic          lz;
  logic          vis;
  logic [7:0]    an_q;
  logic [6:0]    seg_q;

  assign nib = shadow[{idx, 2'b00} +: 4];

  // Digit 0 is exempt so an all-zero word still shows one "0".
  assign lz = LZ_BLANK
           && (idx != 3'd0)
           && ((shadow >> {idx, 2'b00}) == 32'd0);

  assign vis = en_i && (cnt >= BLNK) && !lz;

  always_comb begin
    dec = 7'h7F;
    unique case (nib)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      4'hF: dec = 7'h0E;
      default: dec = 7'h7F;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt    <= '0;
      idx    <= 3'd0;
      shadow <= 32'd0;
      an_q   <= 8'hFF;
      seg_q  <= 7'h7F;
    end else begin
      if (cnt == LAST) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (cnt == '0 && idx == 3'd0)
        shadow <= data_i;
      if (vis) begin
        an_q  <= ~(8'b1 << idx);
        seg_q <= dec;
      end else begin
        an_q  <= 8'hFF;
        seg_q <= 7'h7F;
      end
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = 1'b1;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: three instances cover
// the default blanking, leading-zero suppression and zero-blank handoff.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data = 32'd0;
  logic        en = 1'b1;

  logic [7:0] an0, an1, an2;
  logic [6:0] seg0, seg1, seg2;
  logic       dp0, dp1, dp2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(.DIGIT_CYCLES(4), .BLANK_CYCLES(1), .LZ_BLANK(1'b0)) u0 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .en_i(en),
    .an_o(an0), .seg_o(seg0), .dp_o(dp0)
  );

  seven_seg_scanner #(.DIGIT_CYCLES(4), .BLANK_CYCLES(1), .LZ_BLANK(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .en_i(en),
    .an_o(an1), .seg_o(seg1), .dp_o(dp1)
  );

  seven_seg_scanner #(.DIGIT_CYCLES(4), .BLANK_CYCLES(0), .LZ_BLANK(1'b0)) u2 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .en_i(en),
    .an_o(an2), .seg_o(seg2), .dp_o(dp2)
  );

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] r;
    r = 7'h7F;
    case (n)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h78;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
      4'hA: r = 7'h08;
      4'hB: r = 7'h03;
      4'hC: r = 7'h46;
      4'hD: r = 7'h21;
      4'hE: r = 7'h06;
      4'hF: r = 7'h0E;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] ea;
    logic [6:0] es;
    int c, i;
    data = 32'h12345678;
    en = 1'b1;
    rst = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      total++;
      if (an0 !== 8'hFF || seg0 !== 7'h7F || dp0 !== 1'b1) begin
        bad++;
        $display("FAIL reset_hold t=%0d got an=%h seg=%h dp=%b want an=ff seg=7f dp=1",
                 t, an0, seg0, dp0);
      end
    end
    rst = 1'b0;
    for (int t = 1; t <= 32; t++) begin
      tick();
      c = (t - 1) % 4;
      i = ((t - 1) / 4) % 8;
      ea = (c == 0) ? 8'hFF : ~(8'b1 << i);
      es = (c == 0) ? 7'h7F : hex7(data[i*4 +: 4]);
      total++;
      if (an0 !== ea || seg0 !== es || dp0 !== 1'b1) begin
        bad++;
        $display("FAIL reset_scan t=%0d got an=%h seg=%h dp=%b want an=%h seg=%h dp=1",
                 t, an0, seg0, dp0, ea, es);
      end
    end
  endtask

  task automatic test_atomicity;
    logic [31:0] v;
    logic [7:0]  ea;
    logic [6:0]  es;
    int s, c, i;
    data = 32'h12345678;
    do_reset();
    for (int t = 1; t <= 64; t++) begin
      tick();
      if (t == 10) data = 32'hFFFFFFFF;
      s = t - 1;
      c = s % 4;
      i = (s / 4) % 8;
      v = (s < 32) ? 32'h12345678 : 32'hFFFFFFFF;
      ea = (c == 0) ? 8'hFF : ~(8'b1 << i);
      es = (c == 0) ? 7'h7F : hex7(v[i*4 +: 4]);
      total++;
      if (an0 !== ea || seg0 !== es) begin
        bad++;
        $display("FAIL atomic t=%0d got an=%h seg=%h want an=%h seg=%h",
                 t, an0, seg0, ea, es);
      end
    end
  endtask

  task automatic test_full_decode;
    logic [31:0] v;
    logic [7:0]  ea;
    logic [6:0]  es;
    logic [15:0] seen;
    int s, c, i;
    seen = 16'd0;
    data = 32'hFEDCBA98;
    do_reset();
    for (int t = 1; t <= 64; t++) begin
      tick();
      if (t == 20) data = 32'h76543210;
      s = t - 1;
      c = s % 4;
      i = (s / 4) % 8;
      v = (s < 32) ? 32'hFEDCBA98 : 32'h76543210;
      ea = (c == 0) ? 8'hFF : ~(8'b1 << i);
      es = (c == 0) ? 7'h7F : hex7(v[i*4 +: 4]);
      if (c != 0) seen[v[i*4 +: 4]] = 1'b1;
      total++;
      if (an0 !== ea || seg0 !== es) begin
        bad++;
        $display("FAIL decode t=%0d got an=%h seg=%h want an=%h seg=%h",
                 t, an0, seg0, ea, es);
      end
    end
    total++;
    if (seen !== 16'hFFFF) begin
      bad++;
      $display("FAIL decode_cover got=%h want=ffff", seen);
    end
  endtask

  task automatic test_lz_blank;
    logic [31:0] v;
    logic [7:0]  ea;
    logic [6:0]  es;
    logic        lit;
    int s, c, i;
    data = 32'h000000A0;
    do_reset();
    for (int t = 1; t <= 64; t++) begin
      tick();
      if (t == 5) data = 32'd0;
      s = t - 1;
      c = s % 4;
      i = (s / 4) % 8;
      v = (s < 32) ? 32'h000000A0 : 32'd0;
      lit = (s < 32) ? (i <= 1) : (i == 0);
      ea = (c != 0 && lit) ? ~(8'b1 << i) : 8'hFF;
      es = (c != 0 && lit) ? hex7(v[i*4 +: 4]) : 7'h7F;
      total++;
      if (an1 !== ea || seg1 !== es) begin
        bad++;
        $display("FAIL lz t=%0d got an=%h seg=%h want an=%h seg=%h",
                 t, an1, seg1, ea, es);
      end
    end
  endtask

  task automatic test_enable;
    logic [7:0] ea;
    logic [6:0] es;
    int c, i;
    data = 32'h12345678;
    en = 1'b1;
    do_reset();
    for (int t = 1; t <= 32; t++) begin
      tick();
      if (t == 13) en = 1'b0;
      if (t == 18) en = 1'b1;
      c = (t - 1) % 4;
      i = ((t - 1) / 4) % 8;
      if (c == 0 || (t >= 14 && t <= 18)) begin
        ea = 8'hFF;
        es = 7'h7F;
      end else begin
        ea = ~(8'b1 << i);
        es = hex7(data[i*4 +: 4]);
      end
      total++;
      if (an0 !== ea || seg0 !== es) begin
        bad++;
        $display("FAIL enable t=%0d got an=%h seg=%h want an=%h seg=%h",
                 t, an0, seg0, ea, es);
      end
    end
  endtask

  task automatic test_no_gap;
    logic [7:0] ea;
    logic [6:0] es;
    int s, i;
    data = 32'h12345678;
    do_reset();
    for (int t = 1; t <= 32; t++) begin
      tick();
      s = t - 1;
      i = (s / 4) % 8;
      ea = ~(8'b1 << i);
      // shadow still holds the reset value during the capture cycle
      es = (s == 0) ? 7'h40 : hex7(data[i*4 +: 4]);
      total++;
      if (an2 !== ea || seg2 !== es) begin
        bad++;
        $display("FAIL no_gap t=%0d got an=%h seg=%h want an=%h seg=%h",
                 t, an2, seg2, ea, es);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] ea;
    logic [6:0] es;
    logic [31:0] v;
    int c, i;
    data = 32'h12345678;
    do_reset();
    for (int t = 1; t <= 22; t++) tick();
    total++;
    if (an0 !== 8'hDF || seg0 !== 7'h30) begin
      bad++;
      $display("FAIL mid_pre got an=%h seg=%h want an=df seg=30", an0, seg0);
    end
    rst = 1'b1;
    data = 32'h9ABCDEF0;
    tick();
    total++;
    if (an0 !== 8'hFF || seg0 !== 7'h7F) begin
      bad++;
      $display("FAIL mid_rst got an=%h seg=%h want an=ff seg=7f", an0, seg0);
    end
    rst = 1'b0;
    v = 32'h9ABCDEF0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      c = (t - 1) % 4;
      i = (t - 1) / 4;
      ea = (c == 0) ? 8'hFF : ~(8'b1 << i);
      es = (c == 0) ? 7'h7F : hex7(v[i*4 +: 4]);
      total++;
      if (an0 !== ea || seg0 !== es) begin
        bad++;
        $display("FAIL mid_restart t=%0d got an=%h seg=%h want an=%h seg=%h",
                 t, an0, seg0, ea, es);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(~an0) > 1 || $countones(~an1) > 1 || $countones(~an2) > 1) begin
        bad++;
        $display("FAIL onehot got an0=%h an1=%h an2=%h want at most one low bit",
                 an0, an1, an2);
      end
    end
  end

  initial begin
    test_reset();
    test_atomicity();
    test_full_decode();
    test_lz_blank();
    test_enable();
    test_no_gap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
